// File: rtl/mlaccel_pkg.sv
// rtl/mlaccel_pkg.sv - shared QPI link state type, nibble width and opcodes
package mlaccel_pkg;

   localparam int QPI_NIBBLE_W = 4;

   localparam logic [7:0] OP_WRITE  = 8'h21;
   localparam logic [7:0] OP_READ   = 8'h22;
   localparam logic [7:0] OP_STATUS = 8'h23;
   localparam logic [7:0] OP_CONFIG = 8'h24;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_RX,
      ST_TURN,
      ST_TX
   } link_state_t;

endpackage

// File: rtl/qpi_sync_edge.sv
// rtl/qpi_sync_edge.sv - N-stage input synchroniser with previous-sample register and edge pulses
module qpi_sync_edge #(
   parameter int             STAGES = 2,
   parameter int             W      = 1,
   parameter logic [W-1:0]   INIT   = '0
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [W-1:0] din,
   output logic [W-1:0] sync,
   output logic [W-1:0] prev,
   output logic [W-1:0] rise,
   output logic [W-1:0] fall
);

   logic [W-1:0] chain [STAGES];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) begin
            chain[i] <= INIT;
         end
         prev <= INIT;
      end else begin
         chain[0] <= din;
         for (int i = 1; i < STAGES; i++) begin
            chain[i] <= chain[i-1];
         end
         prev <= chain[STAGES-1];
      end
   end

   assign sync = chain[STAGES-1];
   assign rise = sync & ~prev;
   assign fall = ~sync & prev;

endmodule

// File: rtl/qpi_link_phy.sv
// rtl/qpi_link_phy.sv - QPI slave PHY: oversampled nibble deserialiser and read-phase serialiser
module qpi_link_phy
   import mlaccel_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    qpi_csb,
   input  logic                    qpi_clk,
   input  logic [QPI_NIBBLE_W-1:0] qpi_io_in,
   output logic [QPI_NIBBLE_W-1:0] qpi_io_out,
   output logic                    qpi_io_oe,
   output logic                    rx_valid,
   output logic [7:0]              rx_data,
   output logic                    rx_first,
   input  logic                    tx_start,
   input  logic                    tx_valid,
   input  logic [7:0]              tx_data,
   output logic                    tx_ready,
   output logic                    xfer_end,
   output logic                    link_err
);

   logic csb_sync, csb_prev, csb_rise, csb_fall;
   logic clk_sync, clk_prev, clk_rise, clk_fall;
   logic [QPI_NIBBLE_W-1:0] io_sync, io_prev, io_rise, io_fall;

   qpi_sync_edge #(.STAGES(SYNC_STAGES), .W(1), .INIT(1'b1)) u_csb_sync (
      .clock (clock),
      .reset (reset),
      .din   (qpi_csb),
      .sync  (csb_sync),
      .prev  (csb_prev),
      .rise  (csb_rise),
      .fall  (csb_fall)
   );

   qpi_sync_edge #(.STAGES(SYNC_STAGES), .W(1), .INIT(1'b1)) u_clk_sync (
      .clock (clock),
      .reset (reset),
      .din   (qpi_clk),
      .sync  (clk_sync),
      .prev  (clk_prev),
      .rise  (clk_rise),
      .fall  (clk_fall)
   );

   qpi_sync_edge #(.STAGES(SYNC_STAGES), .W(QPI_NIBBLE_W), .INIT('0)) u_io_sync (
      .clock (clock),
      .reset (reset),
      .din   (qpi_io_in),
      .sync  (io_sync),
      .prev  (io_prev),
      .rise  (io_rise),
      .fall  (io_fall)
   );

   logic unused_sync;
   assign unused_sync = ^{csb_sync, csb_prev, clk_sync, clk_prev, io_sync, io_rise, io_fall};

   link_state_t state, state_next;

   logic [QPI_NIBBLE_W-1:0] nib_hi;
   logic                    nib_pend;
   logic                    turn_seen;
   logic [7:0]              tx_buf;
   logic                    tx_full;

   logic nib_cap, byte_done, err_set, turn_fall, tx_load, drv_hi, drv_lo;

   always_comb begin
      state_next = state;
      nib_cap    = 1'b0;
      byte_done  = 1'b0;
      err_set    = 1'b0;
      turn_fall  = 1'b0;
      tx_load    = 1'b0;
      drv_hi     = 1'b0;
      drv_lo     = 1'b0;
      tx_ready   = 1'b0;
      // csb release outranks any clk edge seen in the same cycle
      if (csb_rise) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (csb_fall) state_next = ST_CMD;
            end
            ST_CMD, ST_RX: begin
               if (clk_rise) begin
                  nib_cap = 1'b1;
               end else if (clk_fall && nib_pend) begin
                  byte_done = 1'b1;
                  if (state == ST_CMD) state_next = ST_RX;
               end
               if (tx_start) begin
                  if (nib_pend) err_set = 1'b1;
                  else          state_next = ST_TURN;
               end
            end
            ST_TURN: begin
               if (clk_fall) turn_fall = 1'b1;
               if (clk_rise && turn_seen) begin
                  state_next = ST_TX;
                  tx_load    = 1'b1;
               end
            end
            ST_TX: begin
               if (clk_fall) drv_hi = 1'b1;
               if (clk_rise) begin
                  drv_lo  = 1'b1;
                  tx_load = 1'b1;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
      tx_ready = tx_load & tx_valid;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         qpi_io_out <= '0;
         qpi_io_oe  <= 1'b0;
         rx_valid   <= 1'b0;
         rx_data    <= '0;
         rx_first   <= 1'b0;
         xfer_end   <= 1'b0;
         link_err   <= 1'b0;
         nib_hi     <= '0;
         nib_pend   <= 1'b0;
         turn_seen  <= 1'b0;
         tx_buf     <= '0;
         tx_full    <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         rx_first <= 1'b0;
         xfer_end <= 1'b0;
         if (csb_rise) begin
            xfer_end   <= 1'b1;
            qpi_io_oe  <= 1'b0;
            qpi_io_out <= '0;
            nib_pend   <= 1'b0;
            turn_seen  <= 1'b0;
            tx_full    <= 1'b0;
         end else begin
            if (state == ST_IDLE && csb_fall) begin
               link_err  <= 1'b0;
               nib_pend  <= 1'b0;
               turn_seen <= 1'b0;
            end
            if (nib_cap) begin
               nib_hi   <= io_prev;
               nib_pend <= 1'b1;
            end
            if (byte_done) begin
               rx_data  <= {nib_hi, io_prev};
               rx_valid <= 1'b1;
               rx_first <= (state == ST_CMD);
               nib_pend <= 1'b0;
            end
            if (err_set)   link_err  <= 1'b1;
            if (turn_fall) turn_seen <= 1'b1;
            if (state == ST_TURN && state_next == ST_TX) begin
               qpi_io_oe <= 1'b1;
               turn_seen <= 1'b0;
            end
            // an empty buffer is zeroed so the low nibble of an underrun byte is also 0
            if (drv_hi) begin
               if (tx_full) begin
                  qpi_io_out <= tx_buf[7:4];
               end else begin
                  qpi_io_out <= '0;
                  tx_buf     <= '0;
                  link_err   <= 1'b1;
               end
            end
            if (drv_lo) begin
               qpi_io_out <= tx_buf[3:0];
               tx_full    <= 1'b0;
            end
            if (tx_ready) begin
               tx_buf  <= tx_data;
               tx_full <= 1'b1;
            end
         end
      end
   end

endmodule
